// File: rtl/ps2_host_ctrl.sv
// PS/2 host sequencer: resets the keyboard, keeps its LEDs in step with caps_lock,
// consumes ACK/BAT/RESEND responses and forwards every other byte to the decoder.
// All outputs registered; dec_ena/dec_code follow rx_valid/rx_data by one cycle.
module ps2_host_ctrl #(
   parameter int TIMEOUT   = 1200000,
   parameter int MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       tx_ready,
   input  logic       tx_done,
   input  logic       caps_lock,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       dec_ena,
   output logic [7:0] dec_code,
   output logic       kbd_ok,
   output logic       busy,
   output logic       cmd_err
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

   typedef enum logic [2:0] {
      S_INIT_FF, S_WAIT_ACK, S_WAIT_BAT, S_IDLE, S_LED_CMD, S_LED_VAL, S_ERROR
   } state_t;

   state_t          state, state_nxt;
   state_t          sent_st;      // send state of the byte in flight, used for resends
   state_t          ret_st;
   logic [TW-1:0]   timer;
   logic [RW-1:0]   retry;
   logic            led_shadow, led_pending;
   logic            send, give_up, retry_inc, retry_clr;
   logic            rsp_ack, rsp_rsnd, rsp_bat, rsp_fail, tmo, last_try, waiting, fwd;
   logic            tx_start_nxt, dec_ena_nxt, kbd_ok_nxt, busy_nxt, cmd_err_nxt;
   logic [7:0]      tx_data_nxt, dec_code_nxt;

   assign rsp_ack  = rx_valid && (rx_data == 8'hFA);
   assign rsp_rsnd = rx_valid && (rx_data == 8'hFE);
   assign rsp_bat  = rx_valid && (rx_data == 8'hAA);
   assign rsp_fail = rx_valid && (rx_data == 8'hFC);
   assign tmo      = (timer == TW'(TIMEOUT - 1));
   assign last_try = (retry == RW'(MAX_RETRY - 1));
   assign waiting  = (state == S_WAIT_ACK) || (state == S_WAIT_BAT);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_INIT_FF;
      else     state <= state_nxt;
   end

   // Next-state logic; a response byte takes priority over a timeout in the same cycle
   always_comb begin
      state_nxt = state;
      send      = 1'b0;
      give_up   = 1'b0;
      retry_inc = 1'b0;
      unique case (sent_st)
         S_INIT_FF: ret_st = S_WAIT_BAT;
         S_LED_CMD: ret_st = S_LED_VAL;
         default:   ret_st = S_IDLE;
      endcase
      unique case (state)
         S_INIT_FF, S_LED_CMD, S_LED_VAL: begin
            if (tx_ready) begin
               send      = 1'b1;
               state_nxt = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (rsp_ack) begin
               state_nxt = ret_st;
            end else if (rsp_rsnd || tmo) begin
               if (last_try) begin
                  give_up   = 1'b1;
                  state_nxt = (sent_st == S_INIT_FF) ? S_ERROR : S_IDLE;
               end else begin
                  retry_inc = 1'b1;
                  state_nxt = sent_st;
               end
            end
         end
         S_WAIT_BAT: begin
            if (rsp_bat) begin
               state_nxt = S_IDLE;
            end else if (rsp_fail || tmo) begin
               if (last_try) begin
                  give_up   = 1'b1;
                  state_nxt = S_ERROR;
               end else begin
                  retry_inc = 1'b1;
                  state_nxt = S_INIT_FF;
               end
            end
         end
         S_IDLE: begin
            if (led_pending && tx_ready) state_nxt = S_LED_CMD;
         end
         default: state_nxt = S_ERROR;
      endcase
   end

   // Output next values; a resend (retry != 0) keeps the byte already in tx_data
   always_comb begin
      tx_start_nxt = send;
      tx_data_nxt  = tx_data;
      if (send && (retry == '0)) begin
         unique case (state)
            S_INIT_FF: tx_data_nxt = 8'hFF;
            S_LED_CMD: tx_data_nxt = 8'hED;
            default:   tx_data_nxt = {5'b0, led_shadow, 2'b00};
         endcase
      end
      fwd = rx_valid
            && !((state == S_WAIT_ACK) && (rsp_ack || rsp_rsnd))
            && !((state == S_WAIT_BAT) && (rsp_bat || rsp_fail));
      dec_ena_nxt  = fwd;
      dec_code_nxt = fwd ? rx_data : dec_code;
      if (state_nxt == S_ERROR)                kbd_ok_nxt = 1'b0;
      else if ((state == S_WAIT_BAT) && rsp_bat) kbd_ok_nxt = 1'b1;
      else                                     kbd_ok_nxt = kbd_ok;
      busy_nxt    = !((state_nxt == S_IDLE) || (state_nxt == S_ERROR));
      cmd_err_nxt = give_up;
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         dec_ena  <= 1'b0;
         dec_code <= 8'h00;
         kbd_ok   <= 1'b0;
         busy     <= 1'b0;
         cmd_err  <= 1'b0;
      end else begin
         tx_start <= tx_start_nxt;
         tx_data  <= tx_data_nxt;
         dec_ena  <= dec_ena_nxt;
         dec_code <= dec_code_nxt;
         kbd_ok   <= kbd_ok_nxt;
         busy     <= busy_nxt;
         cmd_err  <= cmd_err_nxt;
      end
   end

   // Retry counter restarts for each new command byte; FF+BAT share one count
   assign retry_clr = (state == S_IDLE)
                      || ((state == S_WAIT_ACK) && rsp_ack && (sent_st != S_INIT_FF));

   // Timer, retry count, in-flight command and LED tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         timer       <= '0;
         retry       <= '0;
         sent_st     <= S_INIT_FF;
         led_shadow  <= 1'b0;
         led_pending <= 1'b0;
      end else begin
         if (tx_done || (state_nxt != state) || !waiting) timer <= '0;
         else                                              timer <= timer + TW'(1);
         if (retry_clr)      retry <= '0;
         else if (retry_inc) retry <= retry + RW'(1);
         if (send) sent_st <= state;
         // Pending is consumed when a sequence starts, so a change during it re-arms a second one
         if (caps_lock != led_shadow) begin
            led_shadow  <= caps_lock;
            led_pending <= 1'b1;
         end else if ((state == S_WAIT_BAT) && rsp_bat) begin
            led_pending <= 1'b1;
         end else if (((state == S_IDLE) && (state_nxt == S_LED_CMD)) || give_up) begin
            led_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: keyboard/transmitter models drive randomized traffic,
// expected transmit bytes, forwarded bytes and error pulses come from protocol rules.
// Short TIMEOUT so retry/timeout paths run quickly.
module tb_ps2_host_ctrl;
   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_ready, tx_done;
   logic       caps_lock = 1'b0;
   logic       tx_start, dec_ena, kbd_ok, busy, cmd_err;
   logic [7:0] tx_data, dec_code;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         cmd_cnt = 0;
   logic       prev_err = 1'b0;
   logic [7:0] tx_q[$];     // bytes whose transmission completed
   logic [7:0] dec_b[$];    // bytes expected at the decoder
   int         dec_c[$];    // cycle each expected byte was received

   ps2_host_ctrl #(.TIMEOUT(TMO), .MAX_RETRY(3)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_ready(tx_ready), .tx_done(tx_done), .caps_lock(caps_lock),
      .tx_start(tx_start), .tx_data(tx_data), .dec_ena(dec_ena), .dec_code(dec_code),
      .kbd_ok(kbd_ok), .busy(busy), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [7:0] rand_scan();
      logic [7:0] b;
      do b = 8'($urandom_range(0, 255));
      while (b == 8'hFA || b == 8'hFE || b == 8'hAA || b == 8'hFC);
      return b;
   endfunction

   // One received byte; fwd says whether the protocol rules hand it to the decoder
   task automatic send_rx(input logic [7:0] b, input bit fwd);
      rx_valid = 1'b1;
      rx_data  = b;
      if (fwd) begin
         dec_b.push_back(b);
         dec_c.push_back(cyc);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic respond(input logic [7:0] b);
      tick($urandom_range(0, 3));
      send_rx(b, 1'b0);
   endtask

   task automatic wait_tx(input logic [7:0] exp, input string tag);
      int n = 0;
      while (tx_q.size() == 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_seen"}, 32'(tx_q.size() > 0), 1);
      if (tx_q.size() > 0) check(tag, tx_q.pop_front(), exp);
   endtask

   task automatic wait_cmd(input int exp);
      int n = 0;
      while (cmd_cnt < exp && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("cmd_err_cnt", cmd_cnt, exp);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_tx_start"}, tx_start, 0);
      check({tag, "_tx_data"},  tx_data,  8'h00);
      check({tag, "_dec_ena"},  dec_ena,  0);
      check({tag, "_dec_code"}, dec_code, 8'h00);
      check({tag, "_kbd_ok"},   kbd_ok,   0);
      check({tag, "_busy"},     busy,     0);
      check({tag, "_cmd_err"},  cmd_err,  0);
   endtask

   // Transmitter: accepts tx_start, stays busy a few cycles, then pulses tx_done
   initial begin : xmit
      logic [7:0] held;
      bit         saw_rst;
      tx_ready = 1'b1;
      tx_done  = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            check("tx_start_rdy", tx_ready, 1);
            held     = tx_data;
            saw_rst  = 1'b0;
            tx_ready = 1'b0;
            repeat ($urandom_range(2, 5)) begin
               @(negedge clk);
               if (rst) saw_rst = 1'b1;
               check("tx_start_busy", tx_start, 0);
               if (!saw_rst) check("tx_data_hold", tx_data, held);
            end
            tx_done = 1'b1;
            @(negedge clk);
            tx_done  = 1'b0;
            tx_ready = 1'b1;
            tx_q.push_back(held);
         end
      end
   end

   // Decoder side: each strobe must match the next expected byte, one cycle after receipt
   initial begin : dec_mon
      int c;
      forever begin
         @(negedge clk);
         if (dec_ena) begin
            check("dec_expected", 32'(dec_b.size() > 0), 1);
            if (dec_b.size() > 0) begin
               c = dec_c.pop_front();
               check("dec_code", dec_code, dec_b.pop_front());
               check("dec_lat", cyc - c, 1);
            end
         end
      end
   end

   // cmd_err must be a single-cycle pulse
   initial begin : err_mon
      forever begin
         @(negedge clk);
         if (cmd_err) begin
            cmd_cnt++;
            check("cmd_err_pulse", prev_err, 0);
         end
         prev_err = cmd_err;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin : main
      tick(4);
      check_reset("rst");
      rst = 1'b0;

      // Power-up: FF, ACK (with interleaved scan), BAT (FA is a scan byte here), LEDs 00
      wait_tx(8'hFF, "por_ff");
      check("por_busy", busy, 1);
      send_rx(rand_scan(), 1'b1);
      respond(8'hFA);
      tick($urandom_range(0, 2));
      send_rx(8'hFA, 1'b1);
      send_rx(rand_scan(), 1'b1);
      respond(8'hAA);
      check("por_kbd_ok", kbd_ok, 1);
      wait_tx(8'hED, "por_ed");
      respond(8'hFA);
      wait_tx(8'h00, "por_led");
      respond(8'hFA);
      tick(2);
      check("por_idle_busy", busy, 0);

      // Forwarding in IDLE: fixed make/break then random bytes with random gaps
      send_rx(8'h1C, 1'b1);
      send_rx(8'hF0, 1'b1);
      send_rx(8'h1C, 1'b1);
      for (int i = 0; i < 12; i++) begin
         send_rx(8'($urandom_range(0, 255)), 1'b1);
         tick($urandom_range(0, 2));
      end
      check("idle_tx_none", tx_q.size(), 0);

      // Caps on: ED then 04; non-ACK bytes during the wait are forwarded
      caps_lock = 1'b1;
      wait_tx(8'hED, "caps_ed");
      send_rx(8'h23, 1'b1);
      send_rx(8'hAA, 1'b1);
      respond(8'hFA);
      wait_tx(8'h04, "caps_led");
      respond(8'hFA);
      tick(2);
      check("caps_busy", busy, 0);

      // Resend: FE to ED repeats ED, then the sequence completes
      caps_lock = 1'b0;
      wait_tx(8'hED, "rsnd_ed1");
      respond(8'hFE);
      wait_tx(8'hED, "rsnd_ed2");
      respond(8'hFA);
      wait_tx(8'h00, "rsnd_led");
      respond(8'hFA);
      tick(2);
      check("rsnd_busy", busy, 0);

      // LED command abandoned: three attempts, each refused by FE or ignored
      caps_lock = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_tx(8'hED, "gu_ed");
         if ($urandom_range(0, 1) == 1) respond(8'hFE);
      end
      wait_cmd(1);
      check("gu_kbd_ok", kbd_ok, 1);
      check("gu_busy", busy, 0);
      tick(3 * TMO);
      check("gu_no_more_tx", tx_q.size(), 0);

      // Reset while waiting for the LED value ACK
      caps_lock = 1'b0;
      wait_tx(8'hED, "rl_ed");
      respond(8'hFA);
      wait_tx(8'h00, "rl_led");
      rst = 1'b1;
      tick(1);
      check_reset("mid_rst");
      tick(1);
      rst = 1'b0;

      // No reply to FF: three transmissions, then error; bytes still forwarded
      wait_tx(8'hFF, "to_ff1");
      send_rx(rand_scan(), 1'b1);
      wait_tx(8'hFF, "to_ff2");
      wait_tx(8'hFF, "to_ff3");
      wait_cmd(2);
      check("to_kbd_ok", kbd_ok, 0);
      check("to_busy", busy, 0);
      for (int i = 0; i < 6; i++) begin
         send_rx(8'($urandom_range(0, 255)), 1'b1);
         tick($urandom_range(0, 1));
      end
      send_rx(8'hFA, 1'b1);
      send_rx(8'hAA, 1'b1);
      tick(3 * TMO);
      check("err_no_tx", tx_q.size(), 0);
      check("err_dec_drained", dec_b.size(), 0);
      check("err_cmd_total", cmd_cnt, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
